// File: rtl/fpu_pkg.sv
// Shared encodings and pipeline depths for the FP hazard/forwarding logic.
// Latency: none (declarations only).
// Backpressure: n/a.
package fpu_pkg;

  // Operand source selects driven to the ID-stage operand muxes
  typedef enum logic [2:0] {
    FWD_REG = 3'd0,  // register file
    FWD_E3  = 3'd1,  // arith pipe E3 result
    FWD_WBY = 3'd2,  // write port y data (arith WB or divider)
    FWD_WBX = 3'd3,  // write port x data (load WB)
    FWD_MEM = 3'd4   // load data in MEM
  } fwd_sel_e;

  // Issue-to-writeback distance of the arith pipe (E1-E2-E3-WB)
  localparam int ARITH_LAT = 4;
  // Issue-to-writeback distance of lwc1 (EXE-MEM-WB)
  localparam int LOAD_LAT  = 3;

  // One in-flight destination slot
  typedef struct packed {
    logic       vld;
    logic [4:0] fd;
  } stage_t;

endpackage

// File: rtl/fpu_interlock_unit_if.sv
// ID-stage <-> interlock unit bundle: decoded operands in, stall/forward/write-port controls out.
// Latency: none (wires only).
// Backpressure: stall is the only flow control; the ID stage holds its instruction while it is high.
interface fpu_interlock_unit_if;
  logic [4:0] id_fs;
  logic [4:0] id_ft;
  logic [4:0] id_fd;
  logic       id_use_fs;
  logic       id_use_ft;
  logic       id_arith;
  logic       id_div;
  logic       id_lwc1;
  logic       stall;
  logic [2:0] fwd_a;
  logic [2:0] fwd_b;
  logic [4:0] wnx;
  logic       wex;
  logic [4:0] wny;
  logic       wey;
  logic       div_wb;
  logic       div_busy;

  // ID stage side
  modport master (
    output id_fs, id_ft, id_fd, id_use_fs, id_use_ft, id_arith, id_div, id_lwc1,
    input  stall, fwd_a, fwd_b, wnx, wex, wny, wey, div_wb, div_busy
  );

  // Interlock unit side
  modport slave (
    input  id_fs, id_ft, id_fd, id_use_fs, id_use_ft, id_arith, id_div, id_lwc1,
    output stall, fwd_a, fwd_b, wnx, wex, wny, wey, div_wb, div_busy
  );
endinterface

// File: rtl/fpu_div_tracker.sv
// Tracks the single in-flight divide/sqrt: countdown, destination and writeback slot.
// Latency: issue at t -> cnt=DIV_CYCLES at t+1, done (cnt==1) at t+DIV_CYCLES.
// Backpressure: none internally; the caller must only start it while not busy.
module fpu_div_tracker
  import fpu_pkg::*;
#(
  parameter int DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       i_start,
  input  logic [4:0] i_fd,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pend,
  output logic       o_slot_y,
  output logic [4:0] o_fd
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] C_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  // An arith op issued now writes back when the counter has dropped to 1
  localparam logic [CW-1:0] C_SLOT = CW'(ARITH_LAT + 1);

  logic [CW-1:0] r_cnt;
  logic [4:0]    r_fd;

  // Load on start, then count down to zero; reset abandons any divide in flight
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt <= '0;
      r_fd  <= '0;
    end else if (i_start) begin
      r_cnt <= C_LOAD;
      r_fd  <= i_fd;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end

  assign o_busy   = (r_cnt != '0);
  assign o_done   = (r_cnt == C_ONE);
  assign o_pend   = (r_cnt > C_ONE);
  assign o_slot_y = (r_cnt == C_SLOT);
  assign o_fd     = r_fd;

endmodule

// File: rtl/fpu_interlock_unit.sv
// FP register hazard detection, operand forwarding and 2-port regfile write control.
// Latency: stall/fwd combinational from ID; write-port controls registered (arith WB t+4, load WB t+3).
// Backpressure: stall holds IF/ID and injects a bubble; the pipes themselves never stop.
module fpu_interlock_unit
  import fpu_pkg::*;
#(
  parameter int DIV_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 clrn,
  fpu_interlock_unit_if.slave  io_fpu
);

  // r_ar[1..4] = E1,E2,E3,WB ; r_ld[1..3] = EXE,MEM,WB
  stage_t     r_ar [1:ARITH_LAT];
  stage_t     r_ld [1:LOAD_LAT];

  logic       w_is_div, w_is_arith, w_is_lwc1, w_any_op;
  logic       w_div_busy, w_div_done, w_div_pend, w_div_slot;
  logic [4:0] w_div_fd;
  logic [3:0] w_src_a, w_src_b;
  logic       w_struct, w_stall;

  // Decoder should give one-hot; if not, div wins over arith over lwc1
  assign w_is_div   = io_fpu.id_div;
  assign w_is_arith = io_fpu.id_arith & ~io_fpu.id_div;
  assign w_is_lwc1  = io_fpu.id_lwc1 & ~io_fpu.id_div & ~io_fpu.id_arith;
  assign w_any_op   = io_fpu.id_div | io_fpu.id_arith | io_fpu.id_lwc1;

  fpu_div_tracker #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .clrn     (clrn),
    .i_start  (w_is_div & ~w_stall),
    .i_fd     (io_fpu.id_fd),
    .o_busy   (w_div_busy),
    .o_done   (w_div_done),
    .o_pend   (w_div_pend),
    .o_slot_y (w_div_slot),
    .o_fd     (w_div_fd)
  );

  // {stall, select} for one operand; checks run youngest producer first
  function automatic logic [3:0] src_sel(input logic use_r, input logic [4:0] r);
    logic [3:0] res;
    res = {1'b0, FWD_REG};
    if (use_r) begin
      if ((r_ar[1].vld && r_ar[1].fd == r) || (r_ld[1].vld && r_ld[1].fd == r))
        res = {1'b1, FWD_REG};
      else if (r_ar[2].vld && r_ar[2].fd == r)
        res = {1'b1, FWD_REG};
      else if (r_ld[2].vld && r_ld[2].fd == r)
        res = {1'b0, FWD_MEM};
      else if (r_ar[3].vld && r_ar[3].fd == r)
        res = {1'b0, FWD_E3};
      else if (r_ld[3].vld && r_ld[3].fd == r)
        res = {1'b0, FWD_WBX};
      else if ((r_ar[4].vld && r_ar[4].fd == r) || (w_div_done && w_div_fd == r))
        res = {1'b0, FWD_WBY};
      else if (w_div_pend && w_div_fd == r)
        res = {1'b1, FWD_REG};
    end
    return res;
  endfunction

  // RAW resolution for both source operands
  always_comb begin
    w_src_a = src_sel(io_fpu.id_use_fs, io_fpu.id_fs);
    w_src_b = src_sel(io_fpu.id_use_ft, io_fpu.id_ft);
  end

  // Structural and WAW hazards: one divider, shared port y, write ordering to the same reg
  always_comb begin
    w_struct = 1'b0;
    if (w_is_div && w_div_busy)
      w_struct = 1'b1;
    if (w_is_arith && w_div_slot)
      w_struct = 1'b1;
    if (w_is_lwc1 && r_ar[1].vld && r_ar[1].fd == io_fpu.id_fd)
      w_struct = 1'b1;
    if (w_any_op && w_div_pend && w_div_fd == io_fpu.id_fd)
      w_struct = 1'b1;
  end

  assign w_stall = w_src_a[3] | w_src_b[3] | w_struct;

  // Pipes advance every cycle; a stalled or empty ID slot enters as a bubble
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 1; i <= ARITH_LAT; i++) r_ar[i] <= '0;
      for (int i = 1; i <= LOAD_LAT; i++)  r_ld[i] <= '0;
    end else begin
      r_ar[1].vld <= w_is_arith & ~w_stall;
      r_ar[1].fd  <= io_fpu.id_fd;
      for (int i = 2; i <= ARITH_LAT; i++) r_ar[i] <= r_ar[i-1];
      r_ld[1].vld <= w_is_lwc1 & ~w_stall;
      r_ld[1].fd  <= io_fpu.id_fd;
      for (int i = 2; i <= LOAD_LAT; i++) r_ld[i] <= r_ld[i-1];
    end
  end

  assign io_fpu.stall    = w_stall;
  assign io_fpu.fwd_a    = w_src_a[2:0];
  assign io_fpu.fwd_b    = w_src_b[2:0];
  assign io_fpu.wex      = r_ld[LOAD_LAT].vld;
  assign io_fpu.wnx      = r_ld[LOAD_LAT].fd;
  // Issue rules keep arith WB and divider completion from landing in the same cycle
  assign io_fpu.wey      = r_ar[ARITH_LAT].vld | w_div_done;
  assign io_fpu.wny      = w_div_done ? w_div_fd : r_ar[ARITH_LAT].fd;
  assign io_fpu.div_wb   = w_div_done;
  assign io_fpu.div_busy = w_div_busy;

endmodule

// File: tb/tb_fpu_interlock_unit.sv
// Bench for fpu_interlock_unit: cycle table plus divider/reset sequences.
// Write-port activity is scored against a queue of expected writebacks.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_fpu_interlock_unit;
  import fpu_pkg::*;

  localparam int DIV_CYCLES = 8;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  fpu_interlock_unit_if bus();

  fpu_interlock_unit #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .io_fpu (bus)
  );

  typedef struct {
    int         cyc;
    bit         py;
    bit         dv;
    logic [4:0] r;
  } wr_t;

  typedef struct {
    logic       ar, dv, ld;
    logic [4:0] fd, fs, ft;
    logic       ua, ub, st;
    logic [2:0] ea, eb;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[23];
  int   cyc_n  = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_n);
  endtask

  function automatic vec_t mk(input logic ar, dv, ld, input logic [4:0] fd, fs, ft,
                              input logic ua, ub, st, input logic [2:0] ea, eb);
    vec_t v;
    v.ar = ar; v.dv = dv; v.ld = ld; v.fd = fd; v.fs = fs; v.ft = ft;
    v.ua = ua; v.ub = ub; v.st = st; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic drive(input logic ar, dv, ld, input logic [4:0] fd, fs, ft, input logic ua, ub);
    bus.id_arith  = ar;
    bus.id_div    = dv;
    bus.id_lwc1   = ld;
    bus.id_fd     = fd;
    bus.id_fs     = fs;
    bus.id_ft     = ft;
    bus.id_use_fs = ua;
    bus.id_use_ft = ub;
  endtask

  // One ID cycle: present, check stall/forward, record the expected writeback, advance
  task automatic step(input logic ar, dv, ld, input logic [4:0] fd, fs, ft,
                      input logic ua, ub, st, input logic [2:0] ea, eb, input string tag);
    wr_t w;
    drive(ar, dv, ld, fd, fs, ft, ua, ub);
    @(negedge clk);
    chk({tag, " stall"}, bus.stall, st);
    if (!st) begin
      chk({tag, " fwd_a"}, bus.fwd_a, ea);
      chk({tag, " fwd_b"}, bus.fwd_b, eb);
      w.r = fd;
      if (dv) begin
        w.cyc = cyc_n + DIV_CYCLES; w.py = 1'b1; w.dv = 1'b1; sb.push_back(w);
      end else if (ar) begin
        w.cyc = cyc_n + ARITH_LAT;  w.py = 1'b1; w.dv = 1'b0; sb.push_back(w);
      end else if (ld) begin
        w.cyc = cyc_n + LOAD_LAT;   w.py = 1'b0; w.dv = 1'b0; sb.push_back(w);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  // Write-port scoreboard: pop every write due this cycle and compare both ports
  always @(negedge clk) begin
    logic       ex, ey, edv;
    logic [4:0] nx, ny;
    if (mon_en) begin
      ex = 1'b0; ey = 1'b0; edv = 1'b0; nx = '0; ny = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc_n) begin
          if (sb[i].py) begin ey = 1'b1; ny = sb[i].r; edv = sb[i].dv; end
          else          begin ex = 1'b1; nx = sb[i].r; end
          sb.delete(i);
        end
      end
      chk("wex", bus.wex, ex);
      if (ex) chk("wnx", bus.wnx, nx);
      chk("wey", bus.wey, ey);
      if (ey) begin
        chk("wny", bus.wny, ny);
        chk("div_wb", bus.div_wb, edv);
      end
    end
  end

  initial begin
    //            ar dv ld fd  fs ft ua ub st ea eb
    vecs[0]  = mk(1, 0, 0, 3,  1, 2, 1, 1, 0, 0, 0);  // add f3
    vecs[1]  = mk(1, 0, 0, 5,  3, 1, 1, 1, 1, 0, 0);  // f3 in E1
    vecs[2]  = mk(1, 0, 0, 5,  3, 1, 1, 1, 1, 0, 0);  // f3 in E2
    vecs[3]  = mk(1, 0, 0, 5,  3, 1, 1, 1, 0, 1, 0);  // f3 from E3
    vecs[4]  = mk(0, 0, 1, 2,  0, 0, 0, 0, 0, 0, 0);  // lwc1 f2
    vecs[5]  = mk(1, 0, 0, 6,  2, 3, 1, 1, 1, 0, 0);  // f2 in EXE
    vecs[6]  = mk(1, 0, 0, 6,  2, 3, 1, 1, 0, 4, 0);  // f2 from MEM
    vecs[7]  = mk(1, 0, 0, 8,  2, 5, 1, 1, 0, 3, 2);  // f2 load WB, f5 arith WB
    vecs[8]  = mk(1, 0, 0, 7,  1, 1, 1, 1, 0, 0, 0);  // add f7
    vecs[9]  = mk(0, 0, 1, 7,  0, 0, 0, 0, 1, 0, 0);  // lwc1 f7 vs E1 f7
    vecs[10] = mk(0, 0, 1, 7,  0, 0, 0, 0, 0, 0, 0);  // lwc1 f7 issues
    vecs[11] = mk(1, 0, 0, 9,  7, 1, 1, 0, 1, 0, 0);  // load f7 in EXE is youngest
    vecs[12] = mk(1, 0, 0, 9,  7, 1, 1, 0, 0, 4, 0);  // MEM beats arith WB
    vecs[13] = mk(1, 0, 0, 10, 9, 9, 0, 0, 0, 0, 0);  // unused operands ignore E1 f9
    vecs[14] = mk(1, 0, 0, 0,  1, 1, 1, 1, 0, 0, 0);  // add f0
    vecs[15] = mk(1, 0, 0, 11, 0, 0, 1, 1, 1, 0, 0);  // f0 tracked like any reg
    vecs[16] = mk(1, 0, 0, 11, 0, 0, 1, 1, 1, 0, 0);
    vecs[17] = mk(1, 0, 0, 11, 0, 0, 1, 1, 0, 1, 1);
    for (int i = 18; i < 23; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst stall", bus.stall, 0);
    chk("rst fwd_a", bus.fwd_a, 0);
    chk("rst fwd_b", bus.fwd_b, 0);
    chk("rst wex", bus.wex, 0);
    chk("rst wey", bus.wey, 0);
    chk("rst wnx", bus.wnx, 0);
    chk("rst wny", bus.wny, 0);
    chk("rst div_wb", bus.div_wb, 0);
    chk("rst div_busy", bus.div_busy, 0);
    clrn   = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 23; i++)
      step(vecs[i].ar, vecs[i].dv, vecs[i].ld, vecs[i].fd, vecs[i].fs, vecs[i].ft,
           vecs[i].ua, vecs[i].ub, vecs[i].st, vecs[i].ea, vecs[i].eb,
           $sformatf("row%0d", i));

    // Reader of a divide result waits for the completion cycle, then takes port y
    step(0, 1, 0, 4, 1, 2, 1, 1, 0, 0, 0, "div f4");
    for (int k = 1; k < DIV_CYCLES; k++) begin
      step(1, 0, 0, 12, 4, 1, 1, 0, 1, 0, 0, $sformatf("f4 wait%0d", k));
      chk("div_busy during div", bus.div_busy, 1);
    end
    step(1, 0, 0, 12, 4, 1, 1, 0, 0, 2, 0, "f4 from div");
    chk("div_busy after done", bus.div_busy, 0);
    idle(4);

    // Divider busy, div-dest WAW, and the port-y slot collision
    step(0, 1, 0, 13, 1, 1, 1, 1, 0, 0, 0, "div f13");
    step(0, 1, 0, 15, 1, 0, 1, 0, 1, 0, 0, "div while busy");
    step(0, 0, 1, 13, 0, 0, 0, 0, 1, 0, 0, "lwc1 onto div dest");
    idle(1);
    step(1, 0, 0, 14, 1, 1, 1, 1, 1, 0, 0, "arith at cnt5");
    step(1, 0, 0, 14, 1, 1, 1, 1, 0, 0, 0, "arith at cnt4");
    idle(5);

    // Reset in the middle of a divide drops it entirely
    step(0, 1, 0, 16, 1, 1, 1, 1, 0, 0, 0, "div f16");
    idle(5);
    chk("busy before reset", bus.div_busy, 1);
    sb.delete();
    clrn = 1'b0;
    #1;
    chk("reset div_busy", bus.div_busy, 0);
    chk("reset wey", bus.wey, 0);
    chk("reset wex", bus.wex, 0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    step(0, 1, 0, 17, 2, 3, 1, 1, 0, 0, 0, "div after reset");
    idle(DIV_CYCLES + 1);

    chk("writes outstanding", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
